// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back front end.
package rf_wb_arbiter_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding write-back entries for one producer.
module wb_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = rf_wb_arbiter_pkg::wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Buffers ALU and load results, round-robins them onto the RF write port and
// tracks pending writes for RAW stalls.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W     = rf_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W     = rf_wb_arbiter_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 RF_w_en,
  output logic [ADDR_W-1:0]    w_addr,
  output logic [DATA_W-1:0]    w_data
);

  import rf_wb_arbiter_pkg::*;

  localparam int unsigned NumRegs = 2**ADDR_W;

  wb_entry_t           alu_in, ld_in, alu_head, ld_head, win;
  logic                alu_full, alu_empty, ld_full, ld_empty;
  logic                alu_pop, ld_pop, pop;
  src_e                rr_q, rr_d;
  logic [NumRegs-1:0]  busy_q, busy_d;
  logic                w_en_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [DATA_W-1:0]   w_data_q;

  assign alu_in    = '{rd: alu_rd, data: alu_data};
  assign ld_in     = '{rd: ld_rd, data: ld_data};
  assign alu_ready = ~alu_full;
  assign ld_ready  = ~ld_full;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_valid),
    .wdata (alu_in),
    .pop   (alu_pop),
    .rdata (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_valid),
    .wdata (ld_in),
    .pop   (ld_pop),
    .rdata (ld_head),
    .full  (ld_full),
    .empty (ld_empty)
  );

  // The pointer names the source that wins the next contended cycle.
  always_comb begin
    alu_pop = 1'b0;
    ld_pop  = 1'b0;
    rr_d    = rr_q;
    if (!alu_empty && !ld_empty) begin
      if (rr_q == SRC_ALU) begin
        alu_pop = 1'b1;
        rr_d    = SRC_LD;
      end else begin
        ld_pop  = 1'b1;
        rr_d    = SRC_ALU;
      end
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!ld_empty) begin
      ld_pop = 1'b1;
    end
  end

  assign pop = alu_pop | ld_pop;
  assign win = ld_pop ? ld_head : alu_head;

  // Set after clear: a same-cycle issue is younger than the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (pop && (win.rd != '0)) busy_d[win.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= SRC_ALU;
      busy_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
      w_en_q <= pop && (win.rd != '0);
      if (pop) begin
        w_addr_q <= win.rd;
        w_data_q <= win.data;
      end
    end
  end

  assign busy    = busy_q;
  assign RF_w_en = w_en_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic       clk;
  logic       rst;
  logic       alu_valid, ld_valid, issue_valid;
  logic [2:0] alu_rd, ld_rd, issue_rd;
  logic [7:0] alu_data, ld_data;
  logic       alu_ready, ld_ready;
  logic [7:0] busy;
  logic       RF_w_en;
  logic [2:0] w_addr;
  logic [7:0] w_data;

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .RF_w_en     (RF_w_en),
    .w_addr      (w_addr),
    .w_data      (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         src;     // 0 = ALU, 1 = load
    logic [2:0] rd;
    logic [7:0] data;
    bit         exp_en;
  } vec_t;

  vec_t vecs[6];

  logic [10:0] wlog[$];

  always @(posedge clk) begin
    #1;
    if (rst && RF_w_en) wlog.push_back({w_addr, w_data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [2:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  // Each send returns #1 after the edge at which the beat was accepted.
  task automatic send_alu(input logic [2:0] rd, input logic [7:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (alu_ready) begin
        tick();
        alu_valid = 1'b0;
        return;
      end
      tick();
    end
    alu_valid = 1'b0;
    n_vec++;
    n_bad++;
    $display("FAIL alu_handshake: no accept in 50 cycles, required an accept");
  endtask

  task automatic send_ld(input logic [2:0] rd, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_rd    = rd;
    ld_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (ld_ready) begin
        tick();
        ld_valid = 1'b0;
        return;
      end
      tick();
    end
    ld_valid = 1'b0;
    n_vec++;
    n_bad++;
    $display("FAIL ld_handshake: no accept in 50 cycles, required an accept");
  endtask

  initial begin
    int stale;
    int n_ld, n_alu;
    logic [7:0] ld_seen[$];
    logic [7:0] alu_seen[$];

    vecs[0] = '{1'b0, 3'd3, 8'h5A, 1'b1};
    vecs[1] = '{1'b0, 3'd0, 8'hFF, 1'b0};
    vecs[2] = '{1'b1, 3'd7, 8'h80, 1'b1};
    vecs[3] = '{1'b1, 3'd1, 8'h01, 1'b1};
    vecs[4] = '{1'b0, 3'd5, 8'hA5, 1'b1};
    vecs[5] = '{1'b1, 3'd0, 8'h3C, 1'b0};

    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    tick();
    tick();
    chk("rst_en", RF_w_en, 0);
    chk("rst_addr", w_addr, 0);
    chk("rst_data", w_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    rst = 1'b1;
    tick();

    // Single results, one at a time, each preceded by its issue.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].rd);
      chk($sformatf("vec%0d_busy_set", i), busy,
          (vecs[i].rd != 0) ? (32'd1 << vecs[i].rd) : 32'd0);
      if (vecs[i].src) send_ld(vecs[i].rd, vecs[i].data);
      else             send_alu(vecs[i].rd, vecs[i].data);
      chk($sformatf("vec%0d_en_at_accept", i), RF_w_en, 0);
      tick();
      chk($sformatf("vec%0d_en", i), RF_w_en, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        chk($sformatf("vec%0d_addr", i), w_addr, vecs[i].rd);
        chk($sformatf("vec%0d_data", i), w_data, vecs[i].data);
      end
      chk($sformatf("vec%0d_busy_clr", i), busy, 0);
      tick();
      chk($sformatf("vec%0d_en_drop", i), RF_w_en, 0);
    end

    // Same-register set and clear: the issue wins.
    issue(3'd6);
    send_alu(3'd6, 8'hC6);
    issue_valid = 1'b1;
    issue_rd    = 3'd6;
    tick();
    issue_valid = 1'b0;
    chk("coll_en", RF_w_en, 1);
    chk("coll_addr", w_addr, 6);
    chk("coll_busy6", busy, 8'h40);
    // Different registers in the same cycle: both act.
    send_alu(3'd6, 8'h66);
    issue_valid = 1'b1;
    issue_rd    = 3'd2;
    tick();
    issue_valid = 1'b0;
    chk("split_busy", busy, 8'h04);
    send_alu(3'd2, 8'h02);
    tick();
    chk("split_busy_clr", busy, 0);
    tick();

    // Contention from a fresh round-robin pointer.
    do_reset();
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'h11;
    ld_valid  = 1'b1; ld_rd  = 3'd4; ld_data  = 8'h44;
    tick();
    alu_rd = 3'd2; alu_data = 8'h22;
    ld_rd  = 3'd5; ld_data  = 8'h55;
    tick();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    chk("cont0_en", RF_w_en, 1);
    chk("cont0", {w_addr, w_data}, {3'd1, 8'h11});
    tick();
    chk("cont1", {RF_w_en, w_addr, w_data}, {1'b1, 3'd4, 8'h44});
    tick();
    chk("cont2", {RF_w_en, w_addr, w_data}, {1'b1, 3'd2, 8'h22});
    tick();
    chk("cont3", {RF_w_en, w_addr, w_data}, {1'b1, 3'd5, 8'h55});
    tick();
    chk("cont_idle", RF_w_en, 0);

    // Backpressure on the load queue while the ALU streams.
    do_reset();
    wlog.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) send_alu(3'd1, 8'hA0 + 8'(k));
      end
      begin
        send_ld(3'd7, 8'hC0);
        send_ld(3'd7, 8'hC1);
        chk("bp_ld_ready_low", ld_ready, 0);
        send_ld(3'd7, 8'hC2);
        send_ld(3'd7, 8'hC3);
      end
    join
    for (int k = 0; k < 12; k++) tick();
    foreach (wlog[k]) begin
      if (wlog[k][10:8] == 3'd7) ld_seen.push_back(wlog[k][7:0]);
      else                       alu_seen.push_back(wlog[k][7:0]);
    end
    n_ld  = ld_seen.size();
    n_alu = alu_seen.size();
    chk("bp_ld_count", n_ld, 4);
    chk("bp_alu_count", n_alu, 6);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_ld%0d", k), (k < n_ld) ? ld_seen[k] : 8'hxx, 8'hC0 + 8'(k));
    for (int k = 0; k < 6; k++)
      chk($sformatf("bp_alu%0d", k), (k < n_alu) ? alu_seen[k] : 8'hxx, 8'hA0 + 8'(k));

    // Reset in the middle of traffic with queued results.
    issue(3'd5);
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'h11;
    ld_valid  = 1'b1; ld_rd  = 3'd4; ld_data  = 8'h44;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_en", RF_w_en, 0);
    chk("mid_rst_addr", w_addr, 0);
    chk("mid_rst_data", w_data, 0);
    chk("mid_rst_busy", busy, 0);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_ld_ready", ld_ready, 1);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (RF_w_en) stale++;
    end
    chk("post_rst_stale_writes", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
